serial_cmd_ctrl: RTL and testbench
==================================

Name: serial_cmd_ctrl

Overview:
Command sequencer between the UART byte receiver and the life-field engine. Consumes received bytes (rx_byte plus one-cycle rbyte_ready strobe) and parses framed packets. Buffers write payloads and commits them to the shared field memory through a req/ack port only after the checksum passes. Drives the engine's run/step/clear controls.

Parameters:
ADDR_W, 10, field memory word-address width
MAX_LEN, 16, max payload bytes per WRITE packet (power of 2, at most 255)
SYNC, 8'hA5, frame start byte
TIMEOUT, 1000000, max clk74 cycles between bytes inside a packet

Ports:
clk74  in  1  system clock
reset_n  in  1  reset; one clock; asynchronous, active-low
rx_byte  in  8  received byte, valid while rbyte_ready=1
rbyte_ready  in  1  one-cycle strobe per received byte
wr_req  out  1  field memory write request
wr_addr  out  ADDR_W  write address
wr_data  out  8  write data
wr_ack  in  1  memory accepts the word on a cycle where wr_req=1 and wr_ack=1
run  out  1  engine free-run enable (level)
step  out  1  one-cycle single-generation pulse
clear_req  out  1  field-clear request (level)
clear_done  in  1  engine finished clearing
busy  out  1  high in every state except IDLE
err_cnt  out  8  saturating count of dropped packets and bytes

Behaviour:
- Reset values: wr_req=0, wr_addr=0, wr_data=0, run=0, step=0, clear_req=0, busy=0, err_cnt=0, FSM=IDLE, FIFO empty. An asserted reset mid-packet or mid-commit aborts it; the FIFO is discarded.
- Packet format: SYNC, OPC, AH, AL, LEN, DATA x LEN, CSUM.
  - CSUM = XOR of OPC through the last DATA byte.
  - Base address = {AH,AL} truncated to ADDR_W.
- Opcodes:
  - 0x01 WRITE: LEN 1..MAX_LEN.
  - 0x02 RUN, 0x03 STOP, 0x04 STEP, 0x05 CLEAR: LEN must be 0.
- FSM states: IDLE, OPC, AH, AL, LEN, DATA, CSUM, COMMIT, CLR_WAIT.
  - IDLE: advances to OPC only on a byte equal to SYNC. Other bytes are ignored and not counted.
  - OPC -> AH -> AL -> LEN: one byte each.
  - LEN: value 0 goes to CSUM, otherwise to DATA.
  - LEN validation happens on the LEN byte. A bad opcode, LEN=0 for WRITE, LEN>MAX_LEN, or LEN!=0 for a control opcode goes to IDLE with err_cnt+1.
  - DATA: each byte is pushed into a MAX_LEN x 8 FIFO. Go to CSUM after LEN bytes.
  - CSUM on mismatch: go to IDLE, err_cnt+1, FIFO flushed, no side effects.
  - CSUM on match, WRITE: go to COMMIT.
  - CSUM on match, RUN/STOP: run set/cleared on the cycle after the CSUM strobe, then IDLE.
  - CSUM on match, STEP: step=1 for exactly one cycle on the cycle after the CSUM strobe, then IDLE. If run=1, step is still pulsed.
  - CSUM on match, CLEAR: clear_req=1 from the next cycle, go to CLR_WAIT.
- COMMIT:
  - wr_req rises on the cycle after the CSUM strobe, with wr_addr=base and wr_data=FIFO head.
  - Address and data are held stable until wr_ack. On each ack cycle the FIFO pops; the next word (addr+1, wrapping modulo 2^ADDR_W) is presented on the following cycle with wr_req kept high.
  - wr_req drops on the cycle after the last ack; FSM returns to IDLE.
  - With a 1-cycle ack, N bytes take N cycles.
- CLR_WAIT: clear_req held until clear_done is sampled 1. It deasserts on the next cycle and the FSM goes to IDLE. clear_done outside CLR_WAIT is ignored.
- Bytes arriving in COMMIT or CLR_WAIT are dropped and counted in err_cnt.
- Timeout: a 20-bit inter-byte counter clears on each rbyte_ready and runs only in states OPC..CSUM.
  - Reaching TIMEOUT goes to IDLE, err_cnt+1, FIFO flushed.
  - A byte arriving on the same cycle as the timeout takes precedence and no timeout occurs.
- err_cnt saturates at 255, no wrap. Multiple error sources in one cycle add only +1.

Optional Feature:
SERIAL_CMD_ACK_EN
- Defined: adds outputs ack_byte[7:0] and ack_valid (1-cycle pulse, reset 0), produced at packet termination.
  - 8'h00 on successful completion: at the final wr_ack, at clear_done, or at CSUM for RUN/STOP/STEP.
  - 8'hE1 on bad LEN/opcode.
  - 8'hE2 on checksum mismatch.
  - 8'hE3 on timeout.
  - Dropped busy bytes produce no ack.
  - Intended to feed a UART transmitter.
- Undefined: ports absent, no related logic.

Test Plan:
- WRITE A5 01 00 10 03 11 22 33 CSUM=01^00^10^03^11^22^33, wr_ack tied 1 -> wr_req high 3 cycles, after CSUM strobe: addr 0x010/0x011/0x012, data 11/22/33; err_cnt=0.
- Same packet with CSUM wrong -> wr_req never asserts, err_cnt=1, busy falls to 0 the cycle after CSUM.
- WRITE to base 0x3FF, LEN=2, wr_ack alternating 0/1 -> addr 0x3FF then 0x000; each word held stable until acked.
- RUN, STEP, STOP packets -> run=1, then one-cycle step, then run=0; CLEAR -> clear_req held until clear_done pulse, then 0.
- Send A5 01 00 then stall past TIMEOUT -> return to IDLE, err_cnt=1; the next valid packet executes normally.
- Byte arriving during COMMIT with wr_ack held 0 -> err_cnt+1, commit completes intact; reset_n low mid-COMMIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/serial_cmd_ctrl_if.sv
// Byte stream, field-memory write port and engine controls of serial_cmd_ctrl.
// SERIAL_CMD_ACK_EN adds the ack_byte/ack_valid response stream.
interface serial_cmd_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_byte;
  logic              rbyte_ready;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ack;
  logic              run;
  logic              step;
  logic              clear_req;
  logic              clear_done;
  logic              busy;
  logic [7:0]        err_cnt;
`ifdef SERIAL_CMD_ACK_EN
  logic [7:0]        ack_byte;
  logic              ack_valid;
`endif

  modport master (
    input  rx_byte, rbyte_ready, wr_ack, clear_done,
    output wr_req, wr_addr, wr_data, run, step, clear_req, busy, err_cnt
`ifdef SERIAL_CMD_ACK_EN
    , output ack_byte, ack_valid
`endif
  );

  modport slave (
    output rx_byte, rbyte_ready, wr_ack, clear_done,
    input  wr_req, wr_addr, wr_data, run, step, clear_req, busy, err_cnt
`ifdef SERIAL_CMD_ACK_EN
    , input ack_byte, ack_valid
`endif
  );
endinterface

// File: rtl/serial_cmd_ctrl.sv
// Framed command parser: buffers WRITE payloads, commits them after checksum, drives run/step/clear.
// Optional SERIAL_CMD_ACK_EN produces a one-byte status at every packet termination.
module serial_cmd_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic               clk74,
  input logic               reset_n,
  serial_cmd_ctrl_if.master bus
);
  localparam int unsigned PtrW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [19:0] TmrLast = 20'(TIMEOUT - 1);
  localparam logic [7:0]  MaxLen8 = 8'(MAX_LEN);
  localparam logic [7:0]  OpWrite = 8'h01;
  localparam logic [7:0]  OpRun   = 8'h02;
  localparam logic [7:0]  OpStop  = 8'h03;
  localparam logic [7:0]  OpStep  = 8'h04;
  localparam logic [7:0]  OpClear = 8'h05;

  typedef enum logic [3:0] {
    StIdle, StOpc, StAh, StAl, StLen, StData, StCsum, StCommit, StClrWait
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        opc_q, opc_d, ah_q, ah_d, len_q, len_d, cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [19:0]       tmr_q, tmr_d;
  logic              wr_req_q, wr_req_d, run_q, run_d, step_q, step_d, clr_q, clr_d;
  logic [7:0]        fifo_mem [MAX_LEN];
  logic [7:0]        rx;
  logic              rb, push, err_inc, in_parse, timeout, len_ok;

  assign rx       = bus.rx_byte;
  assign rb       = bus.rbyte_ready;
  assign in_parse = state_q inside {StOpc, StAh, StAl, StLen, StData, StCsum};
  // A byte on the expiry cycle wins over the timeout.
  assign timeout  = in_parse && !rb && (tmr_q == TmrLast);

  always_comb begin
    len_ok = 1'b0;
    if (opc_q == OpWrite) begin
      len_ok = (rx != 8'd0) && (rx <= MaxLen8);
    end else if (opc_q inside {OpRun, OpStop, OpStep, OpClear}) begin
      len_ok = (rx == 8'd0);
    end
  end

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    ah_d     = ah_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    addr_d   = addr_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    wr_req_d = wr_req_q;
    run_d    = run_q;
    step_d   = 1'b0;
    clr_d    = clr_q;
    push     = 1'b0;
    err_inc  = 1'b0;
    tmr_d    = (in_parse && !rb) ? tmr_q + 20'd1 : 20'd0;

    unique case (state_q)
      StIdle: if (rb && rx == SYNC) state_d = StOpc;
      StOpc: if (rb) begin
        opc_d   = rx;
        csum_d  = rx;
        state_d = StAh;
      end
      StAh: if (rb) begin
        ah_d    = rx;
        csum_d  = csum_q ^ rx;
        state_d = StAl;
      end
      StAl: if (rb) begin
        addr_d  = ADDR_W'({ah_q, rx});
        csum_d  = csum_q ^ rx;
        state_d = StLen;
      end
      StLen: if (rb) begin
        csum_d = csum_q ^ rx;
        len_d  = rx;
        cnt_d  = 8'd0;
        if (!len_ok) begin
          state_d = StIdle;
          err_inc = 1'b1;
        end else begin
          state_d = (rx == 8'd0) ? StCsum : StData;
        end
      end
      StData: if (rb) begin
        push   = 1'b1;
        csum_d = csum_q ^ rx;
        cnt_d  = cnt_q + 8'd1;
        wptr_d = wptr_q + 1'b1;
        if (cnt_q + 8'd1 == len_q) state_d = StCsum;
      end
      StCsum: if (rb) begin
        state_d = StIdle;
        if (rx != csum_q) begin
          err_inc = 1'b1;
        end else begin
          unique case (opc_q)
            OpWrite: begin
              state_d  = StCommit;
              wr_req_d = 1'b1;
            end
            OpRun:   run_d  = 1'b1;
            OpStop:  run_d  = 1'b0;
            OpStep:  step_d = 1'b1;
            OpClear: begin
              clr_d   = 1'b1;
              state_d = StClrWait;
            end
            default: ;
          endcase
        end
      end
      StCommit: begin
        err_inc = rb;
        // len_q doubles as the count of words still to be accepted.
        if (bus.wr_ack) begin
          rptr_d = rptr_q + 1'b1;
          addr_d = addr_q + 1'b1;
          len_d  = len_q - 8'd1;
          if (len_q == 8'd1) begin
            wr_req_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end
      StClrWait: begin
        err_inc = rb;
        if (bus.clear_done) begin
          clr_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d = StIdle;
      err_inc = 1'b1;
    end
    // Any return to idle discards whatever the FIFO still holds.
    if (state_d == StIdle) begin
      wptr_d = '0;
      rptr_d = '0;
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk74 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      opc_q    <= 8'd0;
      ah_q     <= 8'd0;
      len_q    <= 8'd0;
      cnt_q    <= 8'd0;
      csum_q   <= 8'd0;
      err_q    <= 8'd0;
      addr_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      tmr_q    <= 20'd0;
      wr_req_q <= 1'b0;
      run_q    <= 1'b0;
      step_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      ah_q     <= ah_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      tmr_q    <= tmr_d;
      wr_req_q <= wr_req_d;
      run_q    <= run_d;
      step_q   <= step_d;
      clr_q    <= clr_d;
    end
  end

  always_ff @(posedge clk74) begin
    if (push) fifo_mem[wptr_q] <= rx;
  end

  assign bus.wr_req    = wr_req_q;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = wr_req_q ? fifo_mem[rptr_q] : 8'd0;
  assign bus.run       = run_q;
  assign bus.step      = step_q;
  assign bus.clear_req = clr_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.err_cnt   = err_q;

`ifdef SERIAL_CMD_ACK_EN
  logic       ack_valid_q, ack_valid_d;
  logic [7:0] ack_byte_q, ack_byte_d;

  always_comb begin
    ack_valid_d = 1'b1;
    ack_byte_d  = 8'h00;
    if (timeout) begin
      ack_byte_d = 8'hE3;
    end else if (state_q == StLen && rb && !len_ok) begin
      ack_byte_d = 8'hE1;
    end else if (state_q == StCsum && rb && rx != csum_q) begin
      ack_byte_d = 8'hE2;
    end else if ((state_q == StCsum && rb && opc_q inside {OpRun, OpStop, OpStep}) ||
                 (state_q == StCommit && bus.wr_ack && len_q == 8'd1) ||
                 (state_q == StClrWait && bus.clear_done)) begin
      ack_byte_d = 8'h00;
    end else begin
      ack_valid_d = 1'b0;
      ack_byte_d  = ack_byte_q;
    end
  end

  always_ff @(posedge clk74 or negedge reset_n) begin
    if (!reset_n) begin
      ack_valid_q <= 1'b0;
      ack_byte_q  <= 8'h00;
    end else begin
      ack_valid_q <= ack_valid_d;
      ack_byte_q  <= ack_byte_d;
    end
  end

  assign bus.ack_valid = ack_valid_q;
  assign bus.ack_byte  = ack_byte_q;
`endif
endmodule

// File: tb/tb_serial_cmd_ctrl.sv
// Scoreboard bench for serial_cmd_ctrl: a packet-level model queues expected memory writes and
// engine-control events; an independent monitor pops and compares them as the DUT produces them.
module tb_serial_cmd_ctrl;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TIMEOUT = 64;

  // Event kinds seen on the DUT outputs.
  localparam int EvWrite = 0, EvRun = 1, EvStep = 2, EvClrRise = 3, EvClrFall = 4;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic clk74 = 1'b0;
  logic reset_n;
  always #5 clk74 = ~clk74;

  serial_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  serial_cmd_ctrl #(
    .ADDR_W (ADDR_W),
    .MAX_LEN(MAX_LEN),
    .SYNC   (8'hA5),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk74  (clk74),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  ev_t        exp_q[$];
  logic [7:0] pkt_q[$];
  int         m_err    = 0;
  bit         m_run    = 1'b0;
  int         ack_mode = 1;  // 0 random, 1 always, 2 alternate, 3 held low
  int         req_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic take_event(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d a=%0h d=%0h, expected none (t=%0t)",
               kind, a, d, $time);
    end else begin
      n_checks--;
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_addr", a, e.a);
      check("event_data", d, e.d);
    end
  endtask

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  // Packet-level reference: decides the outcome from the byte list alone.
  task automatic model_packet(output int n_send);
    int         opc, len, base;
    bit         valid;
    logic [7:0] x;
    ev_t        e;
    opc   = pkt_q[1];
    base  = ({pkt_q[2], pkt_q[3]}) % (1 << ADDR_W);
    len   = pkt_q[4];
    valid = (opc == 1) ? (len >= 1 && len <= MAX_LEN) :
            (opc >= 2 && opc <= 5) ? (len == 0) : 1'b0;
    if (!valid) begin
      n_send = 5;
      bump_err();
      return;
    end
    n_send = 6 + len;
    x = 8'h00;
    for (int i = 1; i <= 4 + len; i++) x ^= pkt_q[i];
    if (x != pkt_q[5 + len]) begin
      bump_err();
      return;
    end
    case (opc)
      1: for (int i = 0; i < len; i++) begin
        e.kind = EvWrite; e.a = (base + i) % (1 << ADDR_W); e.d = pkt_q[5 + i];
        exp_q.push_back(e);
      end
      2: begin
        if (!m_run) begin e.kind = EvRun; e.a = 0; e.d = 1; exp_q.push_back(e); end
        m_run = 1'b1;
      end
      3: begin
        if (m_run) begin e.kind = EvRun; e.a = 0; e.d = 0; exp_q.push_back(e); end
        m_run = 1'b0;
      end
      4: begin e.kind = EvStep; e.a = 0; e.d = 0; exp_q.push_back(e); end
      default: begin
        e.kind = EvClrRise; e.a = 0; e.d = 0; exp_q.push_back(e);
        e.kind = EvClrFall; exp_q.push_back(e);
      end
    endcase
  endtask

  task automatic build_pkt(input logic [7:0] opc, input logic [7:0] ah, input logic [7:0] al,
                           input logic [7:0] len, input bit bad_csum);
    logic [7:0] x;
    pkt_q = {8'hA5, opc, ah, al, len};
    for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
    x = 8'h00;
    for (int i = 1; i < pkt_q.size(); i++) x ^= pkt_q[i];
    if (bad_csum) x ^= 8'($urandom_range(1, 255));
    pkt_q.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk74);
    @(posedge clk74);
    #1;
    bus.rx_byte     = b;
    bus.rbyte_ready = 1'b1;
    @(posedge clk74);
    #1;
    bus.rbyte_ready = 1'b0;
  endtask

  task automatic send_pkt(input int max_gap, input bit junk);
    int         n;
    logic [7:0] b;
    model_packet(n);
    if (junk) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, $urandom_range(0, max_gap));
      end
    end
    for (int i = 0; i < n; i++) send_byte(pkt_q[i], $urandom_range(0, max_gap));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk74);
    while (bus.busy && k < budget) begin
      @(negedge clk74);
      k++;
    end
    check("return_to_idle", bus.busy, 1'b0);
  endtask

  task automatic finish_pkt();
    wait_idle(1000);
    repeat (3) @(negedge clk74);
    check("err_cnt", bus.err_cnt, m_err);
    check("events_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_req"}, bus.wr_req, 1'b0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_wr_data"}, bus.wr_data, 8'h00);
    check({tag, "_run"}, bus.run, 1'b0);
    check({tag, "_step"}, bus.step, 1'b0);
    check({tag, "_clear_req"}, bus.clear_req, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_err_cnt"}, bus.err_cnt, 8'h00);
  endtask

  // wr_ack driver
  initial begin
    bus.wr_ack = 1'b0;
    forever begin
      @(posedge clk74);
      #1;
      case (ack_mode)
        0:       bus.wr_ack = 1'($urandom_range(0, 1));
        1:       bus.wr_ack = 1'b1;
        2:       bus.wr_ack = ~bus.wr_ack;
        default: bus.wr_ack = 1'b0;
      endcase
    end
  end

  // Engine model: answers a clear request after a random delay.
  initial begin
    bus.clear_done = 1'b0;
    forever begin
      @(posedge clk74);
      #1;
      if (bus.clear_req && reset_n) begin
        repeat ($urandom_range(0, 6)) @(posedge clk74);
        #1;
        bus.clear_done = 1'b1;
        @(posedge clk74);
        #1;
        bus.clear_done = 1'b0;
        @(posedge clk74);
      end
    end
  end

  // Monitor
  logic              p_req, p_ack, p_run, p_step, p_clr;
  logic [ADDR_W-1:0] p_addr;
  logic [7:0]        p_data;
  int                step_len;
  initial begin
    p_req = 0; p_ack = 0; p_run = 0; p_step = 0; p_clr = 0; p_addr = '0; p_data = '0;
    step_len = 0;
    forever begin
      @(negedge clk74);
      if (!reset_n) begin
        p_req = 0; p_ack = 0; p_run = 0; p_step = 0; p_clr = 0; step_len = 0;
      end else begin
        if (bus.wr_req) req_cycles++;
        if (bus.wr_req && p_req && !p_ack) begin
          check("addr_held", bus.wr_addr, p_addr);
          check("data_held", bus.wr_data, p_data);
        end
        if (bus.wr_req && bus.wr_ack) take_event(EvWrite, bus.wr_addr, bus.wr_data);
        if (bus.run != p_run) take_event(EvRun, 0, bus.run);
        if (bus.step && !p_step) take_event(EvStep, 0, 0);
        if (bus.step) step_len++;
        else if (step_len != 0) begin
          check("step_width", step_len, 1);
          step_len = 0;
        end
        if (bus.clear_req && !p_clr) take_event(EvClrRise, 0, 0);
        if (!bus.clear_req && p_clr) take_event(EvClrFall, 0, 0);
        p_req = bus.wr_req; p_ack = bus.wr_ack; p_run = bus.run; p_step = bus.step;
        p_clr = bus.clear_req; p_addr = bus.wr_addr; p_data = bus.wr_data;
      end
    end
  end

  initial begin
    int n;
    bus.rx_byte     = 8'h00;
    bus.rbyte_ready = 1'b0;
    reset_n         = 1'b1;
    #3 reset_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(posedge clk74);
    #1 reset_n = 1'b1;

    // Three-byte WRITE with immediate ack.
    ack_mode = 1;
    pkt_q = {8'hA5, 8'h01, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
    pkt_q.push_back(8'h01 ^ 8'h00 ^ 8'h10 ^ 8'h03 ^ 8'h11 ^ 8'h22 ^ 8'h33);
    req_cycles = 0;
    send_pkt(0, 1'b0);
    @(negedge clk74);
    check("wr_req_after_csum", bus.wr_req, 1'b1);
    finish_pkt();
    check("wr_req_cycles", req_cycles, 3);

    // Same packet with a corrupted checksum.
    pkt_q[8] = pkt_q[8] ^ 8'h40;
    send_pkt(0, 1'b0);
    @(negedge clk74);
    check("busy_after_bad_csum", bus.busy, 1'b0);
    check("no_wr_req_bad_csum", bus.wr_req, 1'b0);
    finish_pkt();

    // Address wrap from the top of the field with alternating ack.
    ack_mode = 2;
    build_pkt(8'h01, 8'h03, 8'hFF, 8'd2, 1'b0);
    send_pkt(0, 1'b0);
    finish_pkt();

    // Engine controls.
    ack_mode = 1;
    build_pkt(8'h02, 8'h00, 8'h00, 8'd0, 1'b0); send_pkt(1, 1'b0); finish_pkt();
    check("run_level_on", bus.run, 1'b1);
    build_pkt(8'h04, 8'h00, 8'h00, 8'd0, 1'b0); send_pkt(1, 1'b0); finish_pkt();
    build_pkt(8'h03, 8'h00, 8'h00, 8'd0, 1'b0); send_pkt(1, 1'b0); finish_pkt();
    check("run_level_off", bus.run, 1'b0);
    build_pkt(8'h05, 8'h00, 8'h00, 8'd0, 1'b0); send_pkt(1, 1'b0); finish_pkt();

    // Stall mid-packet past the inter-byte limit.
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    repeat (2 * TIMEOUT) @(posedge clk74);
    bump_err();
    finish_pkt();
    build_pkt(8'h01, 8'h01, 8'h23, 8'd4, 1'b0); send_pkt(2, 1'b0); finish_pkt();

    // Byte arriving while a commit is stalled.
    ack_mode = 3;
    build_pkt(8'h01, 8'h00, 8'h40, 8'd4, 1'b0);
    send_pkt(0, 1'b0);
    repeat (2) @(posedge clk74);
    send_byte(8'h55, 0);
    bump_err();
    @(negedge clk74);
    check("err_on_busy_byte", bus.err_cnt, m_err);
    check("busy_during_commit", bus.busy, 1'b1);
    ack_mode = 1;
    finish_pkt();

    // Randomized traffic.
    ack_mode = 0;
    for (int p = 0; p < 150; p++) begin
      int r, opc, len;
      r   = $urandom_range(0, 99);
      opc = (r < 45) ? 1 : (r < 55) ? 2 : (r < 65) ? 3 : (r < 75) ? 4 : (r < 85) ? 5 :
            $urandom_range(0, 255);
      if (opc == 1) len = ($urandom_range(0, 19) == 0) ? $urandom_range(17, 20) * 0 +
                          (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 20)) :
                          $urandom_range(1, MAX_LEN);
      else len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      build_pkt(8'(opc), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'(len),
                ($urandom_range(0, 9) == 0));
      send_pkt(4, 1'b1);
      finish_pkt();
    end

    // Reset asserted in the middle of a commit.
    ack_mode = 3;
    build_pkt(8'h01, 8'h00, 8'h80, 8'd3, 1'b0);
    send_pkt(0, 1'b0);
    repeat (3) @(posedge clk74);
    #1;
    check("commit_pending", bus.wr_req, 1'b1);
    reset_n = 1'b0;
    #1 check_reset_values("mid_commit_reset");
    exp_q.delete();
    m_err = 0;
    m_run = 1'b0;
    repeat (2) @(posedge clk74);
    #1 reset_n = 1'b1;
    ack_mode = 1;
    build_pkt(8'h01, 8'h02, 8'h00, 8'd5, 1'b0); send_pkt(1, 1'b0); finish_pkt();

    // Error counter saturation.
    for (int p = 0; p < 260; p++) begin
      pkt_q = {8'hA5, 8'h07, 8'h00, 8'h00, 8'h00};
      model_packet(n);
      for (int i = 0; i < n; i++) send_byte(pkt_q[i], 0);
    end
    finish_pkt();
    check("err_saturated", bus.err_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
